// File: rtl/lfsr_prbs_chk.sv
// lfsr_prbs_chk: self-synchronizing PRBS checker with lock FSM and error stats.
// Optional bit_count output enabled by defining LFSR_PRBS_CHK_BITCNT_EN.
`timescale 1ns/1ps

module lfsr_prbs_chk #(
    parameter int               width         = 8,
    parameter logic [width-1:0] taps          = 8'hB8,
    parameter int               lock_thresh   = 16,
    parameter int               unlock_thresh = 8,
    parameter int               errcnt_width  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cen,
    input  logic                    din,
    input  logic                    clr_err,
    output logic                    locked,
    output logic                    err,
`ifdef LFSR_PRBS_CHK_BITCNT_EN
    output logic [errcnt_width+15:0] bit_count,
`endif
    output logic [errcnt_width-1:0] err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_T   = 8'(lock_thresh);
    localparam logic [7:0] UNLOCK_T = 8'(unlock_thresh);
    localparam logic [errcnt_width-1:0] CNT_MAX = '1;
    localparam logic [errcnt_width-1:0] CNT_ONE = errcnt_width'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [width-1:0]        sr;
    logic [width-1:0]        sr_nxt;
    logic [7:0]              match_cnt;
    logic [7:0]              match_nxt;
    logic [7:0]              miss_cnt;
    logic [7:0]              miss_nxt;
    logic [errcnt_width-1:0] cnt_nxt;
    logic                    expected;
    logic                    mismatch;
    logic                    count_err;

    assign expected = ^(sr & taps);
    assign mismatch = din ^ expected;
    assign locked   = (state == LOCK);

    // Next-state logic: acquire on din in SEARCH, free-run on prediction in LOCK.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        count_err = 1'b0;
        if (cen) begin
            unique case (state)
                SEARCH: begin
                    sr_nxt = {sr[width-2:0], din};
                    if (mismatch) begin
                        match_nxt = 8'd0;
                    end else if (|sr) begin
                        match_nxt = match_cnt + 8'd1;
                        if (match_nxt == LOCK_T) begin
                            state_nxt = LOCK;
                            match_nxt = 8'd0;
                        end
                    end
                end
                LOCK: begin
                    sr_nxt = {sr[width-2:0], expected};
                    if (mismatch) begin
                        count_err = 1'b1;
                        miss_nxt  = miss_cnt + 8'd1;
                        if (miss_nxt == UNLOCK_T) begin
                            state_nxt = SEARCH;
                            miss_nxt  = 8'd0;
                            match_nxt = 8'd0;
                        end
                    end else begin
                        miss_nxt = 8'd0;
                    end
                end
            endcase
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves one.
    always_comb begin
        cnt_nxt = err_count;
        if (clr_err) begin
            cnt_nxt = count_err ? CNT_ONE : '0;
        end else if (count_err && (err_count != CNT_MAX)) begin
            cnt_nxt = err_count + CNT_ONE;
        end
    end

    // State and output registers; reset overrides cen and clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            match_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err       <= count_err;
            err_count <= cnt_nxt;
        end
    end

`ifdef LFSR_PRBS_CHK_BITCNT_EN
    localparam logic [errcnt_width+15:0] BC_MAX = '1;
    localparam logic [errcnt_width+15:0] BC_ONE = (errcnt_width+16)'(1);

    logic                     bit_hit;
    logic [errcnt_width+15:0] bc_nxt;

    assign bit_hit = cen && (state == LOCK);

    // Saturating count of qualified bits seen while locked.
    always_comb begin
        bc_nxt = bit_count;
        if (clr_err) begin
            bc_nxt = bit_hit ? BC_ONE : '0;
        end else if (bit_hit && (bit_count != BC_MAX)) begin
            bc_nxt = bit_count + BC_ONE;
        end
    end

    // Bit counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
        end else begin
            bit_count <= bc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_prbs_chk.sv
// tb_lfsr_prbs_chk: directed stimulus with a queued scoreboard for lfsr_prbs_chk.
// Two instances share stimulus: 16-bit and 4-bit error counters.
`timescale 1ns/1ps

module tb_lfsr_prbs_chk;

    logic        clk = 1'b0;
    logic        reset;
    logic        cen;
    logic        din;
    logic        clr_err;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic        locked4;
    logic        err4;
    logic [3:0]  err_count4;
`ifdef LFSR_PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count;
    logic [19:0] bit_count4;
`endif

    always #5 clk = ~clk;

    lfsr_prbs_chk #(
        .width(8), .taps(8'hB8), .lock_thresh(16),
        .unlock_thresh(8), .errcnt_width(16)
    ) dut (
        .clk(clk), .reset(reset), .cen(cen), .din(din),
        .clr_err(clr_err), .locked(locked), .err(err),
`ifdef LFSR_PRBS_CHK_BITCNT_EN
        .bit_count(bit_count),
`endif
        .err_count(err_count)
    );

    lfsr_prbs_chk #(
        .width(8), .taps(8'hB8), .lock_thresh(16),
        .unlock_thresh(8), .errcnt_width(4)
    ) dut4 (
        .clk(clk), .reset(reset), .cen(cen), .din(din),
        .clr_err(clr_err), .locked(locked4), .err(err4),
`ifdef LFSR_PRBS_CHK_BITCNT_EN
        .bit_count(bit_count4),
`endif
        .err_count(err_count4)
    );

    typedef struct {
        int id;
        int lk;
        int er;
        int cnt;
        int cnt4;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         step_id = 0;
    logic [7:0] gsr;

    task automatic check(input string nm, input int id,
                         input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d want %0d", nm, id, got, want);
        end
    endtask

    // Monitor: one expectation per clock, checked 1ns after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("locked", e.id, int'(locked), e.lk);
            check("err", e.id, int'(err), e.er);
            check("err_count", e.id, int'(err_count), e.cnt);
            check("locked_w4", e.id, int'(locked4), e.lk);
            check("err_count_w4", e.id, int'(err_count4), e.cnt4);
        end
    end

    task automatic step(input logic r, input logic c, input logic d,
                        input logic cl, input int lk, input int er,
                        input int cnt, input int cnt4);
        exp_t e;
        reset   = r;
        cen     = c;
        din     = d;
        clr_err = cl;
        step_id++;
        e.id   = step_id;
        e.lk   = lk;
        e.er   = er;
        e.cnt  = cnt;
        e.cnt4 = cnt4;
        q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic gen_bit();
        logic fb;
        fb  = ^(gsr & 8'hB8);
        gsr = {gsr[6:0], fb};
        return fb;
    endfunction

    task automatic send(input logic inv, input logic cl, input int lk,
                        input int er, input int cnt, input int cnt4);
        logic b;
        b = gen_bit();
        step(1'b0, 1'b1, b ^ inv, cl, lk, er, cnt, cnt4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        reset   = 1'b1;
        cen     = 1'b0;
        din     = 1'b0;
        clr_err = 1'b0;
        gsr     = 8'h01;
        @(negedge clk);

        // reset wins over cen and clr_err
        step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        // acquisition from seed 01: last mismatch on bit 8, lock on bit 24
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0, (i == 24) ? 1 : 0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, 1, 0, 0, 0);
        end

        // single corrupted bit, then cen low holds state and kills err
        send(1'b1, 1'b0, 1, 1, 1, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 1, 0, 1, 1);
        end

        // clear on a clean bit
        send(1'b0, 1'b1, 1, 0, 0, 0);

        // eight consecutive errors drop lock on the eighth
        for (int k = 1; k <= 8; k++) begin
            send(1'b1, 1'b0, (k < 8) ? 1 : 0, 1, k, k);
        end
        // sr already aligned, so relock on the 16th clean bit
        for (int k = 1; k <= 16; k++) begin
            send(1'b0, 1'b0, (k == 16) ? 1 : 0, 0, 8, 8);
        end

        // saturation of the 4-bit counter with isolated errors
        send(1'b0, 1'b1, 1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            send(1'b1, 1'b0, 1, 1, k, (k > 15) ? 15 : k);
            send(1'b0, 1'b0, 1, 0, k, (k > 15) ? 15 : k);
        end
        // clear coinciding with a counted error leaves one
        send(1'b1, 1'b1, 1, 1, 1, 1);
        send(1'b0, 1'b0, 1, 0, 1, 1);

        // reset during lock with an erroring bit
        b = gen_bit();
        step(1'b1, 1'b1, ~b, 1'b1, 0, 0, 0, 0);

        // all-zero stream must never lock
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        end

        cen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_chk.md
LFSR_PRBS_CHK -- requirements
Module: lfsr_prbs_chk

Interface
REQ-001 Parameter width, default 8: LFSR length in bits, legal range 2..32.
REQ-002 Parameter taps, default 8'hB8: feedback mask of width bits; the feedback bit is the XOR of (shift register AND taps).
REQ-003 Parameter lock_thresh, default 16: consecutive matching bits required to declare lock, legal range 1..255.
REQ-004 Parameter unlock_thresh, default 8: consecutive mismatching bits that drop lock, legal range 1..255.
REQ-005 Parameter errcnt_width, default 16: error counter width.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port cen, input, 1: qualifies din; no state changes while low.
REQ-009 Port din, input, 1: received serial PRBS bit.
REQ-010 Port clr_err, input, 1: synchronous clear of the error statistics.
REQ-011 Port locked, output, 1: checker is synchronized to the stream.
REQ-012 Port err, output, 1: one-cycle pulse for each mismatching bit received while locked.
REQ-013 Port err_count, output, errcnt_width: saturating count of mismatches seen while locked.

Function
REQ-014 The generator model is sr_next = {sr[width-2:0], ^(sr & taps)}, and the transmitted bit is the new bit; the checker SHALL predict expected = ^(sr & taps) on every cen cycle.
REQ-015 The FSM SHALL have two states, SEARCH and LOCK, and SHALL enter SEARCH on reset.
REQ-016 In SEARCH, sr SHALL shift in din (self-synchronizing).
REQ-017 In SEARCH, match_cnt SHALL increment when din==expected and SHALL clear to 0 on a mismatch.
REQ-018 While sr is all zeros in SEARCH, match_cnt SHALL NOT increment, so that the all-zero lock-up state is inhibited.
REQ-019 When match_cnt reaches lock_thresh, the FSM SHALL go to LOCK, with locked=1 on the following cycle.
REQ-020 In LOCK, sr SHALL shift in expected rather than din (free-run), so each corrupted bit counts exactly once.
REQ-021 In LOCK, a mismatch SHALL cause err=1 on the next cycle, increment err_count, and increment miss_cnt.
REQ-022 In LOCK, a match SHALL clear miss_cnt.
REQ-023 When miss_cnt reaches unlock_thresh, the FSM SHALL go to SEARCH: locked=0 the next cycle, match_cnt cleared, and sr reloaded from din on subsequent bits. The mismatch that triggers unlock SHALL still be counted.
REQ-024 err_count SHALL saturate at all-ones and never wrap.
REQ-025 clr_err SHALL zero err_count; if clr_err coincides with a counted error, err_count SHALL become 1.
REQ-026 With cen=0, all state SHALL hold and err SHALL be 0.
REQ-027 err, locked and err_count SHALL be registered outputs with one cycle of latency from the qualifying cen edge.

Reset
REQ-028 reset SHALL take priority over cen and clr_err.
REQ-029 On the cycle after reset, the block SHALL be in SEARCH with sr=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_count=0, and bit_count=0 (when present).
REQ-030 A reset asserted while in LOCK SHALL abort lock immediately with identical values.

Configuration
REQ-031 When macro LFSR_PRBS_CHK_BITCNT_EN is defined, output port bit_count[errcnt_width+15:0] SHALL exist; it counts cen cycles while locked, saturates, and is cleared by reset and clr_err (a clear coinciding with a counted bit yields 1).
REQ-032 When LFSR_PRBS_CHK_BITCNT_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (width=8, taps=8'hB8, lock_thresh=16, unlock_thresh=8)
REQ-033 Reset, then a generator stream seeded 8'h01 with cen=1 -> locked=1 no later than 25 cycles after the first bit; err never pulses; err_count=0.
REQ-034 While locked, invert one bit -> err pulses exactly once; err_count=1; locked stays 1.
REQ-035 While locked, invert 8 consecutive bits -> locked=0 after the 8th; err_count=8; a clean stream then relocks within 24 bits.
REQ-036 After reset, 100 zero bits -> locked stays 0 and err_count stays 0.
REQ-037 With errcnt_width=4, 20 isolated inverted bits while locked -> err_count holds 4'hF; then clr_err on the cycle of a further error -> err_count=1.
REQ-038 Assert reset during LOCK with cen=1 and an erroring bit -> next cycle locked=0, err=0, err_count=0.
